bmult_share_arbiter: RTL

//  Round-robin scheduler that shares one pipelined Bmult WxW multiplier among N requesters.
//  Per-requester valid/ready inputs, at most one operand pair issued per cycle.

---
 rtl/bmult_arb_pkg.sv | 9 +
 rtl/rr_pick.sv | 22 ++
 rtl/bmult_share_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/bmult_arb_pkg.sv
// bmult_arb_pkg: shared types and helpers for the Bmult share arbiter
`timescale 1ns/1ps
package bmult_arb_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} arb_state_t;
   localparam int STAT_W = 16;
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: one-hot round-robin pick of the first request strictly above ptr, wrapping to the lowest
`timescale 1ns/1ps
module rr_pick
   import bmult_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = id_w(N)
)(
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt
);
   logic [N-1:0] above, hi, cand;
   // mask of positions strictly above the pointer
   always_comb begin
      above = '0;
      for (int k = 0; k < N; k++) above[k] = k > int'(ptr);
   end
   assign hi   = req & above;
   assign cand = (|hi) ? hi : req;
   assign gnt  = cand & (~cand + N'(1));
endmodule

// File: rtl/bmult_share_arbiter.sv
// bmult_share_arbiter: round-robin sharing of one pipelined multiplier; BMULT_ARB_STATS_EN adds grant counters
`timescale 1ns/1ps
module bmult_share_arbiter
   import bmult_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int W        = 10,
   parameter int MULT_LAT = 1,
   localparam int IW      = id_w(N_REQ)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [W-1:0]       mult_a,
   output logic [W-1:0]       mult_b,
   input  logic [2*W-1:0]     mult_p,
   output logic               resp_valid,
   output logic [IW-1:0]      resp_id,
   output logic [2*W-1:0]     resp_p,
   output logic               idle
`ifdef BMULT_ARB_STATS_EN
   ,
   output logic [N_REQ*STAT_W-1:0] grant_cnt
`endif
);
   arb_state_t        state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d, win;
   logic [IW-1:0]     tid_q [MULT_LAT+1];
   logic [MULT_LAT:0] tv_q;
   logic [N_REQ-1:0]  gnt;
   logic [W-1:0]      a_q, a_d, b_q, b_d, a_sel, b_sel;
   logic              hs, pend;

   rr_pick #(.N(N_REQ), .IW(IW)) u_pick (.req(req_valid), .ptr(ptr_q), .gnt(gnt));

   assign req_ready = (state_q == RUN && en) ? gnt : '0;
   assign hs        = |req_ready;
   // anything still to arrive besides the stage currently being presented
   assign pend      = |(tv_q << 1);

   // encode the winner and select its operands
   always_comb begin
      win   = '0;
      a_sel = '0;
      b_sel = '0;
      for (int k = 0; k < N_REQ; k++) if (gnt[k]) begin
         win   = IW'(k);
         a_sel = req_a[k*W +: W];
         b_sel = req_b[k*W +: W];
      end
   end

   // next state, pointer and operand registers
   always_comb begin
      state_d = (state_q == IDLE && en)    ? RUN   :
                (state_q == RUN && !en)    ? DRAIN :
                (state_q == DRAIN && !pend) ? IDLE : state_q;
      ptr_d   = hs ? win : ptr_q;
      a_d     = hs ? a_sel : a_q;
      b_d     = hs ? b_sel : b_q;
   end

   // control and operand state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= IW'(N_REQ-1);
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   // id tag pipe aligned with the multiplier latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tv_q <= '0;
         for (int k = 0; k <= MULT_LAT; k++) tid_q[k] <= '0;
      end else begin
         tv_q[0]  <= hs;
         tid_q[0] <= win;
         for (int k = 1; k <= MULT_LAT; k++) begin
            tv_q[k]  <= tv_q[k-1];
            tid_q[k] <= tid_q[k-1];
         end
      end
   end

   assign mult_a     = a_q;
   assign mult_b     = b_q;
   assign resp_valid = tv_q[MULT_LAT];
   assign resp_id    = tid_q[MULT_LAT];
   assign resp_p     = mult_p;
   assign idle       = state_q == IDLE && !(|tv_q);

`ifdef BMULT_ARB_STATS_EN
   logic [STAT_W-1:0] cnt_q [N_REQ];
   // saturating per-requester handshake counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_REQ; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < N_REQ; k++) if (req_ready[k] && cnt_q[k] != '1) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
   end
   for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
      assign grant_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
   end
`endif
endmodule
